// File: rtl/axis_byte_fifo_pkg.sv
// Shared types and helpers for the AXI4-Stream byte FIFO and its bench.
// The optional occupancy output is enabled with the AXIS_FIFO_LEVEL_EN macro.
package axis_byte_fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_ADDR_W = $clog2(FIFO_DEPTH);

  typedef logic [FIFO_ADDR_W:0]   ptr_t;
  typedef logic [FIFO_DATA_W-1:0] data_t;

  // Pointers carry a wrap bit above the address bits, so they count mod 2*DEPTH.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/axis_byte_fifo_ram.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port, no reset.
module axis_byte_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_byte_fifo.sv
// Synchronous first-word-fall-through AXI4-Stream byte FIFO with registered flags and data.
// Define AXIS_FIFO_LEVEL_EN to add the registered occupancy output 'level'.
module axis_byte_fifo
  import axis_byte_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_W,
  parameter int DEPTH      = FIFO_DEPTH,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
`ifdef AXIS_FIFO_LEVEL_EN
  ,
  output logic [ADDR_W:0]       level
`endif
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  // Handshake: a transfer happens on an edge where valid and ready are both
  // high; valid never waits on ready and neither output depends on any input.
  logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
  logic                  s_tready_q, s_tready_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  push, pop;
  logic                  empty_d, full_d;

  assign push = s_axis_tvalid & s_tready_q;
  assign pop  = m_tvalid_q & m_axis_tready;

  always_comb begin
    wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    empty_d    = (wr_ptr_d == rd_ptr_d);
    full_d     = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
                 (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
    s_tready_d = !full_d;
    m_tvalid_d = !empty_d;
    m_tdata_d  = m_tdata_q;
    // The new head may be the byte being written this same edge, which the
    // array cannot return yet, so forward it from the input.
    if (pop || (push && !m_tvalid_q)) begin
      if (push && (rd_ptr_d == wr_ptr_q)) begin
        m_tdata_d = s_axis_tdata;
      end else begin
        m_tdata_d = ram_rdata;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      s_tready_q <= s_tready_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
    end
  end

  axis_byte_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk   (aclk),
    .we    (push),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (s_axis_tdata),
    .raddr (rd_ptr_d[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

`ifdef AXIS_FIFO_LEVEL_EN
  logic [ADDR_W:0] level_q, level_d;

  // Modular difference of the wrap-bit pointers reads DEPTH when full.
  always_comb begin
    level_d = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level = level_q;
`endif

  assign s_axis_tready = s_tready_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;

endmodule

// File: tb/tb_axis_byte_fifo.sv
// Directed bench for axis_byte_fifo: reset, fill/drain, full+pop, random streaming,
// backpressure hold and asynchronous mid-stream reset, with an in-order scoreboard.
module tb_axis_byte_fifo;
  import axis_byte_fifo_pkg::*;

  localparam int W = FIFO_DATA_W;
  localparam int D = FIFO_DEPTH;

  logic         aclk;
  logic         aresetn;
  logic [W-1:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [W-1:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
`ifdef AXIS_FIFO_LEVEL_EN
  logic [FIFO_ADDR_W:0] level;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  ptr_t         mdl_wr;
  ptr_t         mdl_rd;

  axis_byte_fifo dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
`ifdef AXIS_FIFO_LEVEL_EN
    ,
    .level         (level)
`endif
  );

  // Clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mdl_count();
    ptr_t diff;
    diff = mdl_wr - mdl_rd;
    return int'(diff);
  endfunction

  task automatic check_level(input string tag, input int exp);
`ifdef AXIS_FIFO_LEVEL_EN
    check(tag, 32'(level), 32'(exp));
`else
    if (exp < 0) $display("unused level tag %s", tag);
`endif
  endtask

  // Driver: called 1 time unit after a rising edge; checks outputs against the
  // model, applies inputs, then advances one clock and updates the model.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, output logic pushed);
    int  cnt;
    logic do_push, do_pop;
    cnt = mdl_count();
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    m_axis_tready = r;
    check("tready", 32'(s_axis_tready), 32'(cnt < D));
    check("tvalid", 32'(m_axis_tvalid), 32'(cnt > 0));
    if (cnt > 0) check("tdata", 32'(m_axis_tdata), 32'(exp_q[0]));
    check_level("level", cnt);
    do_push = v && (cnt < D);
    do_pop  = r && (cnt > 0);
    @(posedge aclk);
    if (do_pop) begin
      void'(exp_q.pop_front());
      mdl_rd = ptr_inc(mdl_rd);
    end
    if (do_push) begin
      exp_q.push_back(d);
      mdl_wr = ptr_inc(mdl_wr);
    end
    pushed = do_push;
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    mdl_wr = '0;
    mdl_rd = '0;
  endtask

  initial begin
    logic pushed;
    int   sent;
    int   budget;

    model_clear();
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h99;
    m_axis_tready = 1'b0;

    // Reset held 5 cycles with tvalid asserted
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk); #1;
      check("rst_tready", 32'(s_axis_tready), 32'd0);
      check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_tdata", 32'(m_axis_tdata), 32'd0);
      check_level("rst_level", 0);
    end
    @(negedge aclk);
    aresetn       = 1'b1;
    s_axis_tvalid = 1'b0;
    #1;
    check("rel_tready_pre", 32'(s_axis_tready), 32'd0);
    @(posedge aclk); #1;
    check("rel_tready_post", 32'(s_axis_tready), 32'd1);
    check("rel_tvalid_post", 32'(m_axis_tvalid), 32'd0);

    // Fill 0x00..0x0F with no downstream ready, then drain
    for (int i = 0; i < D; i++) cycle(1'b1, 8'(i), 1'b0, pushed);
    check("fill_tready", 32'(s_axis_tready), 32'd0);
    check("fill_tvalid", 32'(m_axis_tvalid), 32'd1);
    check_level("fill_level", 16);
    for (int i = 0; i < D; i++) begin
      check("drain_data", 32'(m_axis_tdata), 32'(i));
      cycle(1'b0, 8'h00, 1'b1, pushed);
    end
    check("drain_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("drain_tready", 32'(s_axis_tready), 32'd1);

    // Full with simultaneous pop: only the pop happens
    for (int i = 0; i < D; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, pushed);
    cycle(1'b1, 8'hA5, 1'b1, pushed);
    check("fullpop_nopush", 32'(pushed), 32'd0);
    check("fullpop_tready", 32'(s_axis_tready), 32'd1);
    check_level("fullpop_level15", 15);
    cycle(1'b1, 8'hA5, 1'b0, pushed);
    check("fullpop_push", 32'(pushed), 32'd1);
    check_level("fullpop_level16", 16);
    for (int i = 1; i < D; i++) begin
      check("fullpop_data", 32'(m_axis_tdata), 32'(8'h10 + i));
      cycle(1'b0, 8'h00, 1'b1, pushed);
    end
    check("fullpop_last", 32'(m_axis_tdata), 32'hA5);
    cycle(1'b0, 8'h00, 1'b1, pushed);
    check("fullpop_empty", 32'(m_axis_tvalid), 32'd0);

    // Random streaming, long enough for the pointers to wrap 2*DEPTH times
    sent   = 0;
    budget = 0;
    while (sent < 1100 && budget < 20000) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), pushed);
      if (pushed) sent++;
      budget++;
    end
    check("stream_budget", 32'(sent), 32'd1100);
    budget = 0;
    while (exp_q.size() > 0 && budget < 100) begin
      cycle(1'b0, 8'h00, 1'b1, pushed);
      budget++;
    end
    check("stream_drained", 32'(exp_q.size()), 32'd0);
    check("stream_tvalid", 32'(m_axis_tvalid), 32'd0);

    // Backpressure: 0x3C held for 7 cycles
    cycle(1'b1, 8'h3C, 1'b0, pushed);
    for (int i = 0; i < 7; i++) begin
      check("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
      check("bp_tdata", 32'(m_axis_tdata), 32'h3C);
      cycle(1'b0, 8'h00, 1'b0, pushed);
    end
    cycle(1'b0, 8'h00, 1'b1, pushed);
    check("bp_popped", 32'(m_axis_tvalid), 32'd0);

    // Mid-stream asynchronous reset with 9 entries stored
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, pushed);
    check_level("mid_level9", 9);
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("mid_tvalid_drop", 32'(m_axis_tvalid), 32'd0);
    check("mid_tready_drop", 32'(s_axis_tready), 32'd0);
    model_clear();
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("mid_tready_back", 32'(s_axis_tready), 32'd1);
    check_level("mid_level0", 0);
    cycle(1'b1, 8'h77, 1'b0, pushed);
    check("mid_next_data", 32'(m_axis_tdata), 32'h77);
    check("mid_next_valid", 32'(m_axis_tvalid), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, pushed);
    check("mid_final_empty", 32'(m_axis_tvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
